freq_div_ctrl: RTL and testbench

FREQ_DIV_CTRL -- requirements
Module: freq_div_ctrl

---
 rtl/freq_div_ctrl.sv | 161 ++++++++++++++++
 tb/tb_freq_div_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/freq_div_ctrl.sv
// Programmable clock-enable style frequency divider with a glitch-free ratio
// change handshake.
//
// Ports:
//   clk        system clock, all logic on rising edge
//   rst        asynchronous active-low reset
//   en         run enable for the divided clock
//   req_valid  new-ratio request strobe
//   req_div    requested divide ratio N
//   req_ready  controller can accept a request (registered)
//   req_err    one-cycle pulse: accepted request had N < 2 (registered)
//   clk_out    divided clock, high for ceil(N/2) of every N cycles (registered)
//   tick       pulse on the first cycle of each clk_out period (registered)
//   cur_div    ratio currently in effect (registered)
//   busy       a ratio change is pending (registered)
module freq_div_ctrl #(
    parameter int unsigned DIV_W   = 4,
    parameter int unsigned DEF_DIV = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             req_valid,
    input  logic [DIV_W-1:0] req_div,
    output logic             req_ready,
    output logic             req_err,
    output logic             clk_out,
    output logic             tick,
    output logic [DIV_W-1:0] cur_div,
    output logic             busy
);

    localparam logic [DIV_W-1:0] DEF_DIV_V = DIV_W'(DEF_DIV);
    localparam logic [DIV_W-1:0] MIN_DIV   = DIV_W'(2);
    localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_nx;
    logic [DIV_W-1:0] cur_div_nx;
    logic [DIV_W-1:0] pend_div;
    logic [DIV_W-1:0] pend_div_nx;

    logic             accept;
    logic             legal;
    logic             period_end;

    logic [DIV_W:0]   half_nx;
    logic             clk_out_nx;
    logic             tick_nx;
    logic             req_err_nx;
    logic             busy_nx;
    logic             req_ready_nx;

    // Request handshake qualifiers; req_ready is already registered from state.
    assign accept     = req_valid && req_ready;
    assign legal      = (req_div >= MIN_DIV);
    assign period_end = (cnt == (cur_div - ONE));

    // State, counter, ratio and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_STOP;
            cnt       <= '0;
            cur_div   <= DEF_DIV_V;
            pend_div  <= DEF_DIV_V;
            clk_out   <= 1'b0;
            tick      <= 1'b0;
            req_err   <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            cur_div   <= cur_div_nx;
            pend_div  <= pend_div_nx;
            clk_out   <= clk_out_nx;
            tick      <= tick_nx;
            req_err   <= req_err_nx;
            busy      <= busy_nx;
            req_ready <= req_ready_nx;
        end
    end

    // Next-state: ratio changes only land at a period boundary or on stop,
    // so clk_out never sees a truncated phase.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        cur_div_nx  = cur_div;
        pend_div_nx = pend_div;
        unique case (state)
            ST_STOP: begin
                cnt_nx = '0;
                if (accept && legal) begin
                    cur_div_nx = req_div;
                end
                if (en) begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_nx = ST_STOP;
                    cnt_nx   = '0;
                    // Stopped anyway, so a legal request can take effect now.
                    if (accept && legal) begin
                        cur_div_nx = req_div;
                    end
                end else begin
                    cnt_nx = period_end ? '0 : cnt + ONE;
                    // Even on the last cycle of a period the request waits a
                    // full period; the wrap here keeps the old ratio.
                    if (accept && legal) begin
                        pend_div_nx = req_div;
                        state_nx    = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if (!en) begin
                    state_nx   = ST_STOP;
                    cnt_nx     = '0;
                    cur_div_nx = pend_div;
                end else if (period_end) begin
                    state_nx   = ST_RUN;
                    cnt_nx     = '0;
                    cur_div_nx = pend_div;
                end else begin
                    cnt_nx = cnt + ONE;
                end
            end
            default: begin
                state_nx = ST_STOP;
                cnt_nx   = '0;
            end
        endcase
    end

    // Output decode on next-cycle values so every output is a flop.
    always_comb begin
        half_nx      = ({1'b0, cur_div_nx} + (DIV_W + 1)'(1)) >> 1;
        clk_out_nx   = 1'b0;
        tick_nx      = 1'b0;
        req_err_nx   = accept && !legal;
        busy_nx      = (state_nx == ST_PEND);
        req_ready_nx = (state_nx != ST_PEND);
        if (state_nx != ST_STOP) begin
            clk_out_nx = ({1'b0, cnt_nx} < half_nx);
            tick_nx    = (cnt_nx == '0);
        end
    end

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Directed bench for freq_div_ctrl (DIV_W=4, DEF_DIV=3).
module tb_freq_div_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       req_valid = 1'b0;
    logic [3:0] req_div = 4'd0;
    logic       req_ready;
    logic       req_err;
    logic       clk_out;
    logic       tick;
    logic [3:0] cur_div;
    logic       busy;

    int checks = 0;
    int errors = 0;

    freq_div_ctrl #(
        .DIV_W   (4),
        .DEF_DIV (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req_valid (req_valid),
        .req_div   (req_div),
        .req_ready (req_ready),
        .req_err   (req_err),
        .clk_out   (clk_out),
        .tick      (tick),
        .cur_div   (cur_div),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        // Asynchronous reset with no clock edge yet.
        #1 rst = 1'b0;
        #1;
        chk1("rst_clk_out", clk_out, 1'b0);
        chk1("rst_tick", tick, 1'b0);
        chk4("rst_cur_div", cur_div, 4'd3);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_ready", req_ready, 1'b1);
        chk1("rst_err", req_err, 1'b0);
        step();
        step();

        // Release with en already high: the first edge starts running.
        rst = 1'b1;
        en  = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            chk1("n3_clk_out", clk_out, (i % 3) < 2);
            chk1("n3_tick", tick, (i % 3) == 0);
            chk4("n3_cur_div", cur_div, 4'd3);
            step();
        end

        // Request N=4 on a cnt=0 cycle; applied at the end of this period.
        chk1("n4_req_tick", tick, 1'b1);
        req_valid = 1'b1;
        req_div   = 4'd4;
        step();
        req_valid = 1'b0;
        chk1("n4_busy", busy, 1'b1);
        chk1("n4_ready", req_ready, 1'b0);
        chk4("n4_old_div", cur_div, 4'd3);
        chk1("n4_old_clk1", clk_out, 1'b1);
        step();
        chk1("n4_old_clk2", clk_out, 1'b0);
        chk1("n4_busy2", busy, 1'b1);
        step();
        chk1("n4_ready_back", req_ready, 1'b1);
        chk1("n4_busy_clr", busy, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk1("n4_clk_out", clk_out, (i % 4) < 2);
            chk1("n4_tick", tick, (i % 4) == 0);
            chk4("n4_cur_div", cur_div, 4'd4);
            step();
        end

        // Request N=5 on the last cycle of a period: one more old period first.
        step();
        step();
        step();
        req_valid = 1'b1;
        req_div   = 4'd5;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk1("n5_old_clk", clk_out, i < 2);
            chk1("n5_old_tick", tick, i == 0);
            chk4("n5_old_div", cur_div, 4'd4);
            chk1("n5_busy", busy, 1'b1);
            step();
        end
        chk1("n5_busy_clr", busy, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk1("n5_clk_out", clk_out, i < 3);
            chk1("n5_tick", tick, i == 0);
            chk4("n5_cur_div", cur_div, 4'd5);
            step();
        end

        // Illegal ratios 1 and 0: single-cycle error pulses, nothing changes.
        req_valid = 1'b1;
        req_div   = 4'd1;
        step();
        req_valid = 1'b0;
        chk1("err1_pulse", req_err, 1'b1);
        chk1("err1_busy", busy, 1'b0);
        chk4("err1_div", cur_div, 4'd5);
        step();
        chk1("err1_clear", req_err, 1'b0);
        req_valid = 1'b1;
        req_div   = 4'd0;
        step();
        req_valid = 1'b0;
        chk1("err0_pulse", req_err, 1'b1);
        chk1("err0_ready", req_ready, 1'b1);
        chk1("err0_clk_out", clk_out, 1'b0);
        step();
        chk1("err0_clear", req_err, 1'b0);
        chk4("err0_div", cur_div, 4'd5);
        step();
        chk1("err0_tick", tick, 1'b1);

        // Pending N=6 then disable: applied with the stop.
        req_valid = 1'b1;
        req_div   = 4'd6;
        step();
        req_valid = 1'b0;
        chk1("n6_busy", busy, 1'b1);
        chk1("n6_clk_hi", clk_out, 1'b1);
        en = 1'b0;
        step();
        chk1("n6_stop_clk", clk_out, 1'b0);
        chk1("n6_stop_tick", tick, 1'b0);
        chk4("n6_stop_div", cur_div, 4'd6);
        chk1("n6_stop_busy", busy, 1'b0);
        chk1("n6_stop_ready", req_ready, 1'b1);
        step();
        chk1("n6_hold_clk", clk_out, 1'b0);
        chk1("n6_hold_tick", tick, 1'b0);
        en = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            chk1("n6_clk_out", clk_out, i < 3);
            chk1("n6_tick", tick, i == 0);
            chk4("n6_cur_div", cur_div, 4'd6);
            step();
        end

        // Reset mid-pend while clk_out is high: immediate, without a clock edge.
        req_valid = 1'b1;
        req_div   = 4'd9;
        step();
        req_valid = 1'b0;
        chk1("pre_rst_busy", busy, 1'b1);
        chk1("pre_rst_clk", clk_out, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk1("arst_clk_out", clk_out, 1'b0);
        chk1("arst_busy", busy, 1'b0);
        chk1("arst_ready", req_ready, 1'b1);
        chk4("arst_cur_div", cur_div, 4'd3);
        en = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk4("post_rst_div", cur_div, 4'd3);
        chk1("post_rst_busy", busy, 1'b0);
        chk1("post_rst_clk", clk_out, 1'b0);

        // Legal request while stopped loads at once; then run at N=2.
        req_valid = 1'b1;
        req_div   = 4'd2;
        step();
        req_valid = 1'b0;
        chk4("stop_load_div", cur_div, 4'd2);
        chk1("stop_load_clk", clk_out, 1'b0);
        chk1("stop_load_tick", tick, 1'b0);
        chk1("stop_load_busy", busy, 1'b0);
        en = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            chk1("n2_clk_out", clk_out, (i % 2) == 0);
            chk1("n2_tick", tick, (i % 2) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
